// File: rtl/pass_verify_pkg.sv
// Shared types for the parking-entry password verifier: FSM states and response codes.
package pass_verify_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StPenalty
    } state_e;

    localparam logic [1:0] RspOk      = 2'b00;
    localparam logic [1:0] RspBadFlat = 2'b01;
    localparam logic [1:0] RspWrong   = 2'b10;
    localparam logic [1:0] RspLocked  = 2'b11;

endpackage

// File: rtl/pass_verify_fsm_if.sv
// Request/response bus of the password verifier; the requester is the master.
interface pass_verify_fsm_if #(
    parameter int unsigned FLAT_W = 4,
    parameter int unsigned PWD_W  = 8
);

    logic              req_valid;
    logic              req_ready;
    logic [FLAT_W-1:0] req_flat;
    logic [PWD_W-1:0]  req_pwd;
    logic              rsp_valid;
    logic [1:0]        rsp_code;
    logic [FLAT_W-1:0] rsp_flat;
    logic              grant;

    modport master (
        output req_valid, req_flat, req_pwd,
        input  req_ready, rsp_valid, rsp_code, rsp_flat, grant
    );

    modport slave (
        input  req_valid, req_flat, req_pwd,
        output req_ready, rsp_valid, rsp_code, rsp_flat, grant
    );

endinterface

// File: rtl/pass_table.sv
// Per-flat password table: programmed bit, saturating fail counter and lock flags.
module pass_table
    import pass_verify_pkg::*;
#(
    parameter int unsigned N_FLATS   = 8,
    parameter int unsigned PWD_W     = 8,
    parameter int unsigned MAX_FAILS = 3,
    parameter int unsigned FLAT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [FLAT_W-1:0]  cfg_flat,
    input  logic [PWD_W-1:0]   cfg_pwd,
    input  logic [FLAT_W-1:0]  lk_flat,
    output logic [PWD_W-1:0]   lk_pwd,
    output logic               lk_programmed,
    output logic               lk_locked,
    input  logic [FLAT_W-1:0]  upd_flat,
    input  logic               upd_clr,
    input  logic               upd_inc,
    output logic [N_FLATS-1:0] locked
);

    localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
    localparam logic [FAIL_W-1:0] MaxFail = FAIL_W'(MAX_FAILS);

    logic [PWD_W-1:0]  pwd_q  [N_FLATS];
    logic [FAIL_W-1:0] fail_q [N_FLATS];
    logic [N_FLATS-1:0] prog_q;

    // Flats are 1-based; entry i holds flat i+1, out-of-range numbers match nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_q <= '0;
            for (int i = 0; i < int'(N_FLATS); i++) begin
                pwd_q[i]  <= '0;
                fail_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_FLATS); i++) begin
                if (upd_flat == FLAT_W'(i + 1)) begin
                    if (upd_clr) begin
                        fail_q[i] <= '0;
                    end else if (upd_inc && fail_q[i] != MaxFail) begin
                        fail_q[i] <= fail_q[i] + 1'b1;
                    end
                end
                // Placed last so a reprogram overrides a same-cycle increment.
                if (cfg_we && cfg_flat == FLAT_W'(i + 1)) begin
                    pwd_q[i]  <= cfg_pwd;
                    prog_q[i] <= 1'b1;
                    fail_q[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        lk_pwd        = '0;
        lk_programmed = 1'b0;
        lk_locked     = 1'b0;
        for (int i = 0; i < int'(N_FLATS); i++) begin
            if (lk_flat == FLAT_W'(i + 1)) begin
                lk_pwd        = pwd_q[i];
                lk_programmed = prog_q[i];
                lk_locked     = (fail_q[i] == MaxFail);
            end
        end
    end

    always_comb begin
        locked = '0;
        for (int i = 0; i < int'(N_FLATS); i++) begin
            locked[i] = (fail_q[i] == MaxFail);
        end
    end

endmodule

// File: rtl/pass_verify_fsm.sv
// Password-verification controller: IDLE/CHECK/PENALTY FSM with registered result
// and grant pulse for reserved-parking entry.
module pass_verify_fsm
    import pass_verify_pkg::*;
#(
    parameter int unsigned N_FLATS        = 8,
    parameter int unsigned PWD_W          = 8,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned PENALTY_CYCLES = 16,
    localparam int unsigned FLAT_W        = $clog2(N_FLATS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    pass_verify_fsm_if.slave   bus,
    input  logic               cfg_we,
    input  logic [FLAT_W-1:0]  cfg_flat,
    input  logic [PWD_W-1:0]   cfg_pwd,
    output logic [N_FLATS-1:0] locked
);

    localparam int unsigned PCNT_W =
        (PENALTY_CYCLES > 0) ? $clog2(PENALTY_CYCLES + 1) : 1;
    localparam logic [PCNT_W-1:0] PenaltyLoad =
        (PENALTY_CYCLES > 0) ? PCNT_W'(PENALTY_CYCLES - 1) : '0;

    state_e state_q, state_d;

    logic [FLAT_W-1:0] flat_q;
    logic [PWD_W-1:0]  pwd_q;
    logic [PCNT_W-1:0] pcnt_q;

    logic              rsp_valid_q;
    logic [1:0]        rsp_code_q;
    logic [FLAT_W-1:0] rsp_flat_q;
    logic              grant_q;

    logic [PWD_W-1:0]  lk_pwd;
    logic              lk_programmed;
    logic              lk_locked;
    logic [1:0]        check_code;
    logic              upd_clr;
    logic              upd_inc;

    pass_table #(
        .N_FLATS   (N_FLATS),
        .PWD_W     (PWD_W),
        .MAX_FAILS (MAX_FAILS),
        .FLAT_W    (FLAT_W)
    ) u_table (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_flat      (cfg_flat),
        .cfg_pwd       (cfg_pwd),
        .lk_flat       (flat_q),
        .lk_pwd        (lk_pwd),
        .lk_programmed (lk_programmed),
        .lk_locked     (lk_locked),
        .upd_flat      (flat_q),
        .upd_clr       (upd_clr),
        .upd_inc       (upd_inc),
        .locked        (locked)
    );

    // Unprogrammed also covers flat 0 and out-of-range flats.
    always_comb begin
        check_code = RspWrong;
        if (!lk_programmed) begin
            check_code = RspBadFlat;
        end else if (lk_locked) begin
            check_code = RspLocked;
        end else if (lk_pwd == pwd_q) begin
            check_code = RspOk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.req_valid) state_d = StCheck;
            StCheck:   state_d = (check_code == RspWrong && PENALTY_CYCLES > 0) ?
                                 StPenalty : StIdle;
            StPenalty: if (pcnt_q == '0) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == StIdle);
        upd_clr       = (state_q == StCheck) && (check_code == RspOk);
        upd_inc       = (state_q == StCheck) && (check_code == RspWrong);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flat_q <= '0;
            pwd_q  <= '0;
        end else if (state_q == StIdle && bus.req_valid) begin
            flat_q <= bus.req_flat;
            pwd_q  <= bus.req_pwd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else if (state_q == StCheck) begin
            pcnt_q <= PenaltyLoad;
        end else if (state_q == StPenalty && pcnt_q != '0) begin
            pcnt_q <= pcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= RspOk;
            rsp_flat_q  <= '0;
            grant_q     <= 1'b0;
        end else begin
            rsp_valid_q <= (state_q == StCheck);
            grant_q     <= (state_q == StCheck) && (check_code == RspOk);
            if (state_q == StCheck) begin
                rsp_code_q <= check_code;
                rsp_flat_q <= flat_q;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_code  = rsp_code_q;
    assign bus.rsp_flat  = rsp_flat_q;
    assign bus.grant     = grant_q;

endmodule

// File: tb/tb_pass_verify_fsm.sv
// Directed and randomized bench for pass_verify_fsm against a per-flat table model.
module tb_pass_verify_fsm;

    localparam int unsigned NF = 8;
    localparam int unsigned PW = 8;
    localparam int unsigned MF = 3;
    localparam int unsigned PC = 16;
    localparam int unsigned FW = 4;

    logic clk = 1'b0;
    logic rst;
    logic cfg_we;
    logic [FW-1:0] cfg_flat;
    logic [PW-1:0] cfg_pwd;
    logic [NF-1:0] locked;

    int vectors = 0;
    int miscompares = 0;

    logic [PW-1:0] m_pwd  [1:NF];
    bit            m_prog [1:NF];
    int            m_fail [1:NF];

    always #5 clk = ~clk;

    pass_verify_fsm_if #(.FLAT_W(FW), .PWD_W(PW)) bus ();

    pass_verify_fsm #(
        .N_FLATS        (NF),
        .PWD_W          (PW),
        .MAX_FAILS      (MF),
        .PENALTY_CYCLES (PC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cfg_we   (cfg_we),
        .cfg_flat (cfg_flat),
        .cfg_pwd  (cfg_pwd),
        .locked   (locked)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 1; i <= int'(NF); i++) begin
            m_pwd[i]  = '0;
            m_prog[i] = 1'b0;
            m_fail[i] = 0;
        end
    endfunction

    function automatic void model_cfg(input int f, input logic [PW-1:0] p);
        if (f >= 1 && f <= int'(NF)) begin
            m_pwd[f]  = p;
            m_prog[f] = 1'b1;
            m_fail[f] = 0;
        end
    endfunction

    function automatic logic [1:0] model_code(input int f, input logic [PW-1:0] p);
        if (f < 1 || f > int'(NF)) return 2'b01;
        if (!m_prog[f]) return 2'b01;
        if (m_fail[f] >= int'(MF)) return 2'b11;
        if (p == m_pwd[f]) return 2'b00;
        return 2'b10;
    endfunction

    function automatic logic [NF-1:0] model_locked();
        logic [NF-1:0] v;
        for (int i = 1; i <= int'(NF); i++) v[i-1] = (m_fail[i] == int'(MF));
        return v;
    endfunction

    task automatic do_cfg(input int f, input logic [PW-1:0] p);
        cfg_we = 1'b1;
        cfg_flat = FW'(f);
        cfg_pwd = p;
        @(negedge clk);
        cfg_we = 1'b0;
        model_cfg(f, p);
        check("cfg_locked", locked, model_locked());
    endtask

    // cfg_at / rst_at: penalty cycle (1-based) at which to reprogram flat 3 or reset; 0 = never.
    task automatic req(input int f, input logic [PW-1:0] p, input int cfg_at, input int rst_at);
        logic [1:0] exp;
        int n;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", bus.req_ready, 1);
        exp = model_code(f, p);
        bus.req_valid = 1'b1;
        bus.req_flat = FW'(f);
        bus.req_pwd = p;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_flat = FW'($urandom_range(0, 15));
        bus.req_pwd = PW'($urandom);
        check("ready_in_check", bus.req_ready, 0);
        check("rsp_early", bus.rsp_valid, 0);
        @(negedge clk);
        if (exp == 2'b00) m_fail[f] = 0;
        if (exp == 2'b10) m_fail[f]++;
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_code", bus.rsp_code, exp);
        check("rsp_flat", bus.rsp_flat, f);
        check("grant", bus.grant, exp == 2'b00);
        check("locked", locked, model_locked());
        check("ready_after", bus.req_ready, exp != 2'b10);
        if (exp != 2'b10) begin
            @(negedge clk);
            check("rsp_pulse", bus.rsp_valid, 0);
            return;
        end
        n = 1;
        forever begin
            if (n == cfg_at) begin
                cfg_we = 1'b1;
                cfg_flat = FW'(3);
                cfg_pwd = 8'h5A;
            end
            if (n == rst_at) rst = 1'b1;
            @(negedge clk);
            if (n == cfg_at) begin
                cfg_we = 1'b0;
                model_cfg(3, 8'h5A);
                check("penalty_cfg_locked", locked, model_locked());
            end
            if (n == rst_at) begin
                rst = 1'b0;
                model_reset();
                check("rst_no_rsp", bus.rsp_valid, 0);
                @(negedge clk);
                check("rst_ready", bus.req_ready, 1);
                check("rst_locked", locked, 0);
                check("rst_no_rsp2", bus.rsp_valid, 0);
                return;
            end
            check("penalty_rsp_pulse", bus.rsp_valid, 0);
            if (bus.req_ready) break;
            n++;
            if (n > int'(PC) + 4) break;
        end
        check("penalty_len", n, PC);
    endtask

    initial begin
        logic [PW-1:0] pool [4];
        pool[0] = 8'hA5;
        pool[1] = 8'h5A;
        pool[2] = 8'h00;
        pool[3] = 8'h11;
        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_flat = '0;
        cfg_pwd = '0;
        bus.req_valid = 1'b0;
        bus.req_flat = '0;
        bus.req_pwd = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_code", bus.rsp_code, 0);
        check("reset_rsp_flat", bus.rsp_flat, 0);
        check("reset_grant", bus.grant, 0);
        check("reset_locked", locked, 0);
        check("reset_ready", bus.req_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        do_cfg(3, 8'hA5);
        req(3, 8'hA5, 0, 0);
        req(0, 8'hA5, 0, 0);
        req(9, 8'hA5, 0, 0);
        req(5, 8'hA5, 0, 0);
        req(15, 8'h00, 0, 0);

        repeat (3) req(3, 8'h00, 0, 0);
        check("flat3_locked", locked[2], 1);
        req(3, 8'hA5, 0, 0);

        do_cfg(4, 8'h11);
        req(4, 8'h00, 3, 0);
        check("flat3_unlocked", locked[2], 0);
        req(3, 8'h5A, 0, 0);

        repeat (2) req(3, 8'h00, 0, 0);
        req(3, 8'h5A, 0, 0);
        repeat (2) req(3, 8'h00, 0, 0);
        check("flat3_not_locked", locked[2], 0);

        for (int i = 1; i <= 6; i++) do_cfg(i, pool[$urandom_range(0, 3)]);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                do_cfg(int'($urandom_range(0, 10)), pool[$urandom_range(0, 3)]);
            req(int'($urandom_range(0, 10)), pool[$urandom_range(0, 3)], 0, 0);
        end

        do_cfg(3, 8'h5A);
        req(3, 8'h00, 0, 5);
        req(3, 8'h5A, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
